// File: rtl/redirect_pkg.sv
// Shared definitions for the redirect sequencer: FSM encoding, interrupt
// source tags and the default Z80 vector addresses.
package redirect_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PAGE_WAIT = 2'd1,
        INT_WAIT  = 2'd2,
        VECTOR    = 2'd3
    } state_t;

    localparam logic INT_SRC = 1'b0;
    localparam logic NMI_SRC = 1'b1;

    localparam logic [15:0] DEFAULT_INT_VECTOR = 16'h0038;
    localparam logic [15:0] DEFAULT_NMI_VECTOR = 16'h0066;

endpackage

// File: rtl/irq_enable_ff.sv
// Z80 interrupt enable flip-flops IFF1/IFF2 plus the one-instruction EI shadow.
// An interrupt acknowledge takes precedence over EI/DI/RETN in the same cycle.
module irq_enable_ff (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    input  logic ei,
    input  logic di,
    input  logic retn,
    input  logic eoi,
    input  logic ack,
    input  logic ack_nmi,
    output logic iff1,
    output logic iff2,
    output logic ei_delay
);

    // NOTE: state flops use non-blocking assignments so every update in this
    // block sees the pre-edge values (iff2 <= iff1 reads the old iff1).
    always_ff @(posedge clk) begin
        if (reset) begin
            iff1     <= 1'b0;
            iff2     <= 1'b0;
            ei_delay <= 1'b0;
        end else if (!stall) begin
            if (ack) begin
                if (ack_nmi) begin
                    iff2 <= iff1;
                    iff1 <= 1'b0;
                end else begin
                    iff1 <= 1'b0;
                    iff2 <= 1'b0;
                end
                if (eoi) ei_delay <= 1'b0;
            end else if (ei) begin
                // The EI shadow survives an EOI in the EI cycle itself.
                iff1     <= 1'b1;
                iff2     <= 1'b1;
                ei_delay <= 1'b1;
            end else begin
                if (eoi) ei_delay <= 1'b0;
                if (di) begin
                    iff1 <= 1'b0;
                    iff2 <= 1'b0;
                end else if (retn) begin
                    iff1 <= iff2;
                end
            end
        end
    end

endmodule

// File: rtl/redirect_sequencer.sv
// Arbitrates paging and interrupt flush requests toward the flush unit and,
// after an interrupt service redirect, issues a one-shot vector fetch.
module redirect_sequencer
    import redirect_pkg::*;
#(
    parameter logic [15:0] INT_VECTOR = DEFAULT_INT_VECTOR,
    parameter logic [15:0] NMI_VECTOR = DEFAULT_NMI_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq_line,
    input  logic        nmi_in,
    input  logic        paging_write,
    input  logic        ei_exe,
    input  logic        di_exe,
    input  logic        retn_exe,
    input  logic        EOI_EXE_stage,
    input  logic        br_taken,
    input  logic        mem_pipe_stall,
    input  logic        PCupdate,
    input  logic [15:0] targetPC,
    output logic        paging_RQ,
    output logic        interrupt_RQ,
    output logic        vector_valid,
    output logic [15:0] vector_pc,
    output logic [15:0] ret_pc,
    output logic        int_ack,
    output logic        iff1,
    output logic        iff2
);

    state_t      state_q, state_d;
    logic        int_src_q, int_src_d;
    logic        nmi_prev_q, nmi_pend_q, page_pend_q;
    logic [15:0] ret_pc_q;
    logic        ei_delay;
    logic        capture_ret, page_clear;

    // Live events are OR-ed with their pending flops so arbitration reacts
    // in the same cycle the event arrives.
    logic nmi_rise, page_req, nmi_req, int_eligible, vector_fire;
    assign nmi_rise     = nmi_in & ~nmi_prev_q;
    assign page_req     = page_pend_q | paging_write;
    assign nmi_req      = nmi_pend_q | nmi_rise;
    assign int_eligible = irq_line & iff1 & ~ei_delay;
    assign vector_fire  = (state_q == VECTOR) & ~mem_pipe_stall;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        int_src_d   = int_src_q;
        capture_ret = 1'b0;
        page_clear  = 1'b0;
        if (!mem_pipe_stall) begin
            unique case (state_q)
                IDLE: begin
                    if (page_req) begin
                        state_d = PAGE_WAIT;
                    end else if (nmi_req) begin
                        state_d   = INT_WAIT;
                        int_src_d = NMI_SRC;
                    end else if (int_eligible) begin
                        state_d   = INT_WAIT;
                        int_src_d = INT_SRC;
                    end
                end
                PAGE_WAIT: begin
                    if (PCupdate) begin
                        state_d    = IDLE;
                        page_clear = 1'b1;
                    end
                end
                INT_WAIT: begin
                    if (page_req) begin
                        state_d = PAGE_WAIT;
                    end else if (PCupdate && !br_taken) begin
                        state_d     = VECTOR;
                        capture_ret = 1'b1;
                    end else if (int_src_q == INT_SRC && !int_eligible) begin
                        state_d = IDLE;
                    end
                end
                VECTOR:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            int_src_q   <= INT_SRC;
            nmi_prev_q  <= 1'b0;
            nmi_pend_q  <= 1'b0;
            page_pend_q <= 1'b0;
            ret_pc_q    <= 16'h0000;
        end else begin
            state_q     <= state_d;
            int_src_q   <= int_src_d;
            nmi_prev_q  <= nmi_in;
            // Capture stays live during stalls; a new event beats a clear.
            page_pend_q <= paging_write | (page_pend_q & ~page_clear);
            nmi_pend_q  <= nmi_rise |
                           (nmi_pend_q & ~(vector_fire & (int_src_q == NMI_SRC)));
            if (capture_ret) ret_pc_q <= targetPC;
        end
    end

    irq_enable_ff u_irq_enable_ff (
        .clk      (clk),
        .reset    (reset),
        .stall    (mem_pipe_stall),
        .ei       (ei_exe),
        .di       (di_exe),
        .retn     (retn_exe),
        .eoi      (EOI_EXE_stage),
        .ack      (vector_fire),
        .ack_nmi  (int_src_q == NMI_SRC),
        .iff1     (iff1),
        .iff2     (iff2),
        .ei_delay (ei_delay)
    );

    assign paging_RQ    = (state_q == PAGE_WAIT);
    assign interrupt_RQ = (state_q == INT_WAIT);
    assign vector_valid = (state_q == VECTOR);
    assign int_ack      = (state_q == VECTOR);
    assign vector_pc    = (state_q != VECTOR)       ? 16'h0000 :
                          (int_src_q == NMI_SRC)    ? NMI_VECTOR : INT_VECTOR;
    assign ret_pc       = ret_pc_q;

endmodule
